// File: rtl/gol_pkg.sv
// Shared types and default sizing for the Game of Life shift-chain controller.
package gol_pkg;

  localparam int NCELLS_DEF = 64;
  localparam int WORD_W_DEF = 8;
  localparam int GEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    OP_LOAD   = 2'd0,
    OP_RUN    = 2'd1,
    OP_UNLOAD = 2'd2,
    OP_RSVD   = 2'd3
  } gol_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_UNLOAD = 2'd3
  } gol_state_e;

endpackage

// File: rtl/gol_shift_ctrl_if.sv
// Host-side command / load / readback bus of the shift-chain controller.
interface gol_shift_ctrl_if
  import gol_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int GEN_W  = GEN_W_DEF
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [GEN_W-1:0]  cmd_gens;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out_data;
  logic              busy;

  modport master (
    output cmd_valid, cmd_op, cmd_gens, in_valid, in_data, out_ready,
    input  cmd_ready, in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_gens, in_valid, in_data, out_ready,
    output cmd_ready, in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/gol_serdes.sv
// Word-wide shift register with bit counter. Serialises a loaded word LSB
// first, or deserialises incoming bits (first bit ends up in bit 0).
module gol_serdes
  import gol_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_load_data,
  input  logic              i_shift,
  input  logic              i_capture,
  input  logic              i_bit,
  output logic              o_full,
  output logic              o_bit0,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_done
);
  localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(WORD_W - 1);

  logic [WORD_W-1:0] r_sr;
  logic [BW-1:0]     r_bcnt;
  logic              r_full;
  logic              w_fill;
  logic              w_last;

  assign w_fill      = i_capture & i_bit;
  assign w_last      = (r_bcnt == B_LAST);
  assign o_full      = r_full;
  assign o_bit0      = r_sr[0];
  // Completed word as it will look once the current bit is shifted in.
  assign o_word      = {i_bit, r_sr[WORD_W-1:1]};
  assign o_word_done = i_shift & i_capture & w_last;

  // Shift register, bit counter and full flag; both directions shift right.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sr   <= {WORD_W{1'b0}};
      r_bcnt <= {BW{1'b0}};
      r_full <= 1'b0;
    end else if (i_clr) begin
      r_sr   <= {WORD_W{1'b0}};
      r_bcnt <= {BW{1'b0}};
      r_full <= 1'b0;
    end else if (i_load) begin
      r_sr   <= i_load_data;
      r_bcnt <= {BW{1'b0}};
      r_full <= 1'b1;
    end else if (i_shift) begin
      r_sr <= {w_fill, r_sr[WORD_W-1:1]};
      if (w_last) begin
        r_bcnt <= {BW{1'b0}};
        r_full <= 1'b0;
      end else begin
        r_bcnt <= r_bcnt + BW'(1);
      end
    end
  end
endmodule

// File: rtl/gol_shift_ctrl.sv
// Host controller for the Game of Life systolic array: loads the board through
// the shift chain, runs generations, and reads the board back by recirculation.
module gol_shift_ctrl
  import gol_pkg::*;
#(
  parameter int NCELLS = NCELLS_DEF,
  parameter int WORD_W = WORD_W_DEF,
  parameter int GEN_W  = GEN_W_DEF
) (
  input  logic            clock,
  input  logic            reset_n,
  gol_shift_ctrl_if.slave host,
  output logic            Shift,
  output logic            DataIn,
  output logic            NextTimeTick,
  input  logic            array_tail
);
  localparam int SCW = $clog2(NCELLS + 1);
  localparam logic [SCW-1:0] SC_LAST = SCW'(NCELLS - 1);
  localparam logic [SCW-1:0] SC_END  = SCW'(NCELLS);

  gol_state_e        r_state;
  gol_state_e        w_state_nxt;
  logic              r_cmd_ready;
  logic              r_busy;
  logic [SCW-1:0]    r_scnt;
  logic [GEN_W-1:0]  r_gcnt;
  logic              r_out_valid;
  logic [WORD_W-1:0] r_out_data;

  gol_op_e           w_op;
  logic              w_cmd_acc;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_shift;
  logic              w_din;
  logic              w_tick;
  logic              w_sd_full;
  logic              w_sd_bit0;
  logic [WORD_W-1:0] w_sd_word;
  logic              w_sd_done;

  assign w_op      = gol_op_e'(host.cmd_op);
  assign w_cmd_acc = (r_state == ST_IDLE) & r_cmd_ready & host.cmd_valid;
  assign w_in_xfer = w_in_ready & host.in_valid;

  gol_serdes #(.WORD_W(WORD_W)) u_serdes (
    .clock       (clock),
    .reset_n     (reset_n),
    .i_clr       (w_cmd_acc),
    .i_load      (w_in_xfer),
    .i_load_data (host.in_data),
    .i_shift     (w_shift),
    .i_capture   (r_state == ST_UNLOAD),
    .i_bit       (array_tail),
    .o_full      (w_sd_full),
    .o_bit0      (w_sd_bit0),
    .o_word      (w_sd_word),
    .o_word_done (w_sd_done)
  );

  // Next-state decode and array-side strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_shift     = 1'b0;
    w_din       = 1'b0;
    w_tick      = 1'b0;
    w_in_ready  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_cmd_acc) begin
          case (w_op)
            OP_LOAD:   w_state_nxt = ST_LOAD;
            OP_RUN:    w_state_nxt = ST_RUN;
            OP_UNLOAD: w_state_nxt = ST_UNLOAD;
            default:   w_state_nxt = ST_IDLE;
          endcase
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Shift only while a captured word is still draining.
        w_in_ready = ~w_sd_full;
        w_shift    = w_sd_full;
        w_din      = w_sd_full & w_sd_bit0;
        if (w_sd_full && (r_scnt == SC_LAST)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (r_gcnt == GEN_W'(0)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_tick = 1'b1;
          if (r_gcnt == GEN_W'(1)) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
      end
      ST_UNLOAD: begin
        if (r_scnt != SC_END) begin
          // Stall while a finished word is not being taken this cycle.
          w_shift     = ~(r_out_valid & ~host.out_ready);
          w_din       = w_shift & array_tail;
          w_state_nxt = ST_UNLOAD;
        end else if (r_out_valid && host.out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_UNLOAD;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register with registered idle/busy status.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_busy      <= (w_state_nxt != ST_IDLE);
    end
  end

  // Shift and generation counters, rearmed on every accepted command.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scnt <= {SCW{1'b0}};
      r_gcnt <= {GEN_W{1'b0}};
    end else if (w_cmd_acc) begin
      r_scnt <= {SCW{1'b0}};
      r_gcnt <= host.cmd_gens;
    end else begin
      if (w_shift) begin
        r_scnt <= r_scnt + SCW'(1);
      end
      if (w_tick) begin
        r_gcnt <= r_gcnt - GEN_W'(1);
      end
    end
  end

  // Readback word holding register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {WORD_W{1'b0}};
    end else if (w_sd_done) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sd_word;
    end else if (r_out_valid && host.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign host.cmd_ready = r_cmd_ready;
  assign host.busy      = r_busy;
  assign host.in_ready  = w_in_ready;
  assign host.out_valid = r_out_valid;
  assign host.out_data  = r_out_data;
  assign Shift          = w_shift;
  assign DataIn         = w_din;
  assign NextTimeTick   = w_tick;
endmodule

// File: tb/tb_gol_shift_ctrl.sv
// Directed bench: gol_shift_ctrl driving a behavioural 8x8 toroidal Life array.
module tb_gol_shift_ctrl;
  import gol_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  logic Shift, DataIn, NextTimeTick, array_tail;

  always #5 clock = ~clock;

  gol_shift_ctrl_if #(.WORD_W(8), .GEN_W(16)) hif ();

  gol_shift_ctrl #(.NCELLS(64), .WORD_W(8), .GEN_W(16)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .host         (hif),
    .Shift        (Shift),
    .DataIn       (DataIn),
    .NextTimeTick (NextTimeTick),
    .array_tail   (array_tail)
  );

  // Array: cell i feeds cell i+1; board word k bit b lives in cell 63-(8k+b).
  logic [63:0] cells = 64'd0;
  logic s_shift = 1'b0, s_din = 1'b0, s_tick = 1'b0;
  int checks = 0, errors = 0;
  int viol = 0, n_shift = 0, n_tick = 0, n_busy = 0;
  logic [7:0] rdq[$];
  logic [7:0] rd[8];

  assign array_tail = cells[63];

  function automatic logic [63:0] life_step(input logic [63:0] cur);
    logic [63:0] nx;
    int n, rr, cc;
    nx = 64'd0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (dr != 0 || dc != 0) begin
              rr = (r + dr + 8) % 8;
              cc = (c + dc + 8) % 8;
              n += int'(cur[63 - (8 * rr + cc)]);
            end
          end
        end
        if (n == 3 || (n == 2 && cur[63 - (8 * r + c)])) nx[63 - (8 * r + c)] = 1'b1;
      end
    end
    return nx;
  endfunction

  // Mid-cycle monitor: latch strobes for the array, count events, log transfers.
  always @(negedge clock) begin
    s_shift = Shift;
    s_din   = DataIn;
    s_tick  = NextTimeTick;
    if (Shift) n_shift++;
    if (NextTimeTick) n_tick++;
    if (hif.busy) n_busy++;
    if (Shift && NextTimeTick) viol++;
    if (DataIn && !Shift) viol++;
    if (Shift && hif.out_valid && !hif.out_ready) viol++;
    if (Shift && hif.in_ready) viol++;
    if (hif.out_valid && hif.out_ready) rdq.push_back(hif.out_data);
  end

  // Cell array update.
  always @(posedge clock) begin
    if (s_tick) cells <= life_step(cells);
    else if (s_shift) cells <= {cells[62:0], s_din};
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1, "watchdog");
  end

  task automatic do_cmd(input logic [1:0] op, input logic [15:0] gens);
    int g = 0;
    hif.cmd_op = op; hif.cmd_gens = gens; hif.cmd_valid = 1'b1;
    while (!hif.cmd_ready && g < 100) begin @(posedge clock); #1; g++; end
    if (g >= 100) begin
      checks++; errors++;
      $display("FAIL cmd_accept: cmd_ready=%b, required 1", hif.cmd_ready);
    end
    @(posedge clock); #1;
    hif.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int g = 0;
    while (hif.busy && g < limit) begin @(posedge clock); #1; g++; end
    if (g >= limit) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy=%b, required 0", hif.busy);
    end
  endtask

  task automatic send_words(input logic [63:0] w, input int nw, input int gap);
    int g;
    for (int k = 0; k < nw; k++) begin
      repeat (gap) begin @(posedge clock); #1; end
      hif.in_data = w[8*k +: 8]; hif.in_valid = 1'b1; g = 0;
      while (!hif.in_ready && g < 200) begin @(posedge clock); #1; g++; end
      if (g >= 200) begin
        checks++; errors++;
        $display("FAIL in_ready_timeout: word %0d in_ready=%b, required 1", k, hif.in_ready);
      end
      @(posedge clock); #1;
      hif.in_valid = 1'b0;
    end
  endtask

  task automatic load_board(input logic [63:0] w, input int gap);
    n_shift = 0;
    do_cmd(OP_LOAD, 16'd0);
    send_words(w, 8, gap);
    wait_idle(200);
  endtask

  task automatic unload_board(input int pat);
    int g = 0;
    rdq.delete(); n_shift = 0;
    do_cmd(OP_UNLOAD, 16'd0);
    while (!(rdq.size() == 8 && !hif.busy) && g < 2000) begin
      hif.out_ready = (pat == 0) ? 1'b1 : ((g % 4) == 0);
      @(posedge clock); #1; g++;
    end
    hif.out_ready = 1'b0;
    if (g >= 2000) begin
      checks++; errors++;
      $display("FAIL unload_timeout: words=%0d busy=%b, required 8 words and idle", rdq.size(), hif.busy);
    end
    for (int k = 0; k < 8; k++) rd[k] = (k < rdq.size()) ? rdq[k] : 8'hxx;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    hif.cmd_valid = 1'b0; hif.cmd_op = 2'd0; hif.cmd_gens = 16'd0;
    hif.in_valid = 1'b0; hif.in_data = 8'd0; hif.out_ready = 1'b0;
    #3;
    checks++;
    if ({Shift, NextTimeTick, DataIn, hif.in_ready, hif.out_valid, hif.busy, hif.out_data} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, required all 0",
               {Shift, NextTimeTick, DataIn, hif.in_ready, hif.out_valid, hif.busy, hif.out_data});
    end
    #19 reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b, required 1", hif.cmd_ready); end
    checks++;
    if (hif.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", hif.busy); end
  endtask

  task automatic test_load_unload;
    logic [63:0] exp = 64'h0807060504030201;
    load_board(exp, 0);
    checks++;
    if (n_shift !== 64) begin errors++; $display("FAIL t1_load_shifts: got %0d, required 64", n_shift); end
    for (int p = 0; p < 2; p++) begin
      unload_board(0);
      checks++;
      if (n_shift !== 64) begin errors++; $display("FAIL t1_unload_shifts pass %0d: got %0d, required 64", p, n_shift); end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd[k] !== exp[8*k +: 8]) begin
          errors++; $display("FAIL t1_word%0d pass %0d: got %02h, required %02h", k, p, rd[k], exp[8*k +: 8]);
        end
      end
    end
  endtask

  task automatic test_blinker;
    logic [63:0] horiz = 64'h0000_0000_1C00_0000;
    logic [63:0] vert  = 64'h0000_0008_0808_0000;
    logic [63:0] exp;
    int          gens_tab[3] = '{1, 2, 1};
    load_board(horiz, 0);
    for (int s = 0; s < 3; s++) begin
      n_tick = 0;
      do_cmd(OP_RUN, 16'(gens_tab[s]));
      wait_idle(100);
      checks++;
      if (n_tick !== gens_tab[s]) begin errors++; $display("FAIL t2_ticks step %0d: got %0d, required %0d", s, n_tick, gens_tab[s]); end
      exp = (s == 2) ? horiz : vert;
      unload_board(0);
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd[k] !== exp[8*k +: 8]) begin
          errors++; $display("FAIL t2_row%0d step %0d: got %02h, required %02h", k, s, rd[k], exp[8*k +: 8]);
        end
      end
    end
  endtask

  task automatic test_run_zero;
    logic [63:0] exp = 64'h0000_0000_1C00_0000;
    n_tick = 0; n_busy = 0;
    do_cmd(OP_RUN, 16'd0);
    repeat (4) begin @(posedge clock); #1; end
    checks++;
    if (n_busy !== 1) begin errors++; $display("FAIL t3_busy_cycles: got %0d, required 1", n_busy); end
    checks++;
    if (n_tick !== 0) begin errors++; $display("FAIL t3_ticks: got %0d, required 0", n_tick); end
    unload_board(0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd[k] !== exp[8*k +: 8]) begin errors++; $display("FAIL t3_row%0d: got %02h, required %02h", k, rd[k], exp[8*k +: 8]); end
    end
  endtask

  task automatic test_back_to_back_backpressure;
    logic [63:0] exp = 64'hF00F_A55A_3CC3_8001;
    load_board(exp, 0);
    viol = 0;
    for (int p = 1; p >= 0; p--) begin
      unload_board(p);
      checks++;
      if (n_shift !== 64) begin errors++; $display("FAIL t4_shifts pat %0d: got %0d, required 64", p, n_shift); end
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd[k] !== exp[8*k +: 8]) begin
          errors++; $display("FAIL t4_word%0d pat %0d: got %02h, required %02h", k, p, rd[k], exp[8*k +: 8]);
        end
      end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL t4_protocol: violations %0d, required 0", viol); end
  endtask

  task automatic test_load_gaps;
    logic [63:0] exp = 64'h0123_4567_89AB_CDEF;
    viol = 0;
    load_board(exp, 5);
    checks++;
    if (n_shift !== 64) begin errors++; $display("FAIL t5_load_shifts: got %0d, required 64", n_shift); end
    unload_board(0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd[k] !== exp[8*k +: 8]) begin errors++; $display("FAIL t5_word%0d: got %02h, required %02h", k, rd[k], exp[8*k +: 8]); end
    end
    checks++;
    if (viol !== 0) begin errors++; $display("FAIL t5_protocol: violations %0d, required 0", viol); end
  endtask

  task automatic test_reset_mid_load;
    logic [63:0] exp = 64'h6996_0FF0_5AA5_C33C;
    do_cmd(OP_LOAD, 16'd0);
    send_words(64'hFFFF_FFFF_FFFF_FFFF, 3, 0);
    checks++;
    if (Shift !== 1'b1) begin errors++; $display("FAIL t6_shift_before_reset: got %b, required 1", Shift); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({Shift, NextTimeTick, DataIn, hif.in_ready, hif.out_valid, hif.busy, hif.out_data} !== 14'd0) begin
      errors++;
      $display("FAIL t6_reset_outputs: got %b, required all 0",
               {Shift, NextTimeTick, DataIn, hif.in_ready, hif.out_valid, hif.busy, hif.out_data});
    end
    #6 reset_n = 1'b1;
    @(posedge clock); #1;
    checks++;
    if (hif.cmd_ready !== 1'b1) begin errors++; $display("FAIL t6_cmd_ready: got %b, required 1", hif.cmd_ready); end
    load_board(exp, 0);
    unload_board(0);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rd[k] !== exp[8*k +: 8]) begin errors++; $display("FAIL t6_word%0d: got %02h, required %02h", k, rd[k], exp[8*k +: 8]); end
    end
  endtask

  initial begin
    test_reset();
    test_load_unload();
    test_blinker();
    test_run_zero();
    test_back_to_back_backpressure();
    test_load_gaps();
    test_reset_mid_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
